// File: rtl/uart_cmd_frame_parser_pkg.sv
// Shared constants and state encoding for the UART command frame parser.
package uart_cmd_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] BCAST_ID  = 8'hFF;

    typedef enum logic [2:0] {
        S_SYNC    = 3'd0,
        S_ID      = 3'd1,
        S_LEN     = 3'd2,
        S_PAYLOAD = 3'd3,
        S_CHK     = 3'd4
    } state_t;

endpackage

// File: rtl/uart_cmd_frame_parser_if.sv
// Receiver-side byte input and committed-frame outputs of the frame parser.
interface uart_cmd_frame_parser_if #(
    parameter int unsigned MAX_LEN = 8
);
    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

    logic                   rx_flag;
    logic [7:0]             rx_byte;
    logic                   frame_valid;
    logic [7:0]             frame_id;
    logic [LEN_W-1:0]       frame_len;
    logic [8*MAX_LEN-1:0]   frame_payload;
    logic                   err_chk;
    logic                   err_len;
    logic                   err_timeout;
    logic                   busy;

    modport master (
        output rx_flag, rx_byte,
        input  frame_valid, frame_id, frame_len, frame_payload,
        input  err_chk, err_len, err_timeout, busy
    );

    modport slave (
        input  rx_flag, rx_byte,
        output frame_valid, frame_id, frame_len, frame_payload,
        output err_chk, err_len, err_timeout, busy
    );

endinterface

// File: rtl/uart_cmd_frame_parser_byte_strobe.sv
// Turns the receiver's multi-cycle byte flag into a single registered strobe
// and captures the byte on that strobe.
module uart_byte_strobe (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_flag,
    input  logic [7:0] rx_byte,
    output logic       byte_stb,
    output logic [7:0] rx_data
);

    logic rx_flag_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_flag_q <= 1'b0;
            byte_stb  <= 1'b0;
            rx_data   <= 8'h00;
        end else begin
            rx_flag_q <= rx_flag;
            byte_stb  <= rx_flag & ~rx_flag_q;
            if (rx_flag & ~rx_flag_q) begin
                rx_data <= rx_byte;
            end
        end
    end

endmodule

// File: rtl/uart_cmd_frame_parser.sv
// Parses SYNC|ID|LEN|PAYLOAD|CHK frames from the UART byte stream and commits
// validated payloads addressed to this bot (or broadcast) to held outputs.
module uart_cmd_frame_parser
    import uart_cmd_pkg::*;
#(
    parameter logic [7:0]  BOT_ID         = 8'h01,
    parameter int unsigned MAX_LEN        = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic                    clk,
    input  logic                    rst,
    uart_cmd_frame_parser_if.slave  bus
);

    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);
    localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES);

    logic             byte_stb;
    logic [7:0]       rx_data;
    state_t           state, state_next;
    logic [7:0]       id_q;
    logic [7:0]       chk_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] idx_q;
    logic [7:0]       shadow [MAX_LEN];
    logic [TMR_W-1:0] timer_q;

    logic commit_c, err_chk_c, err_len_c, err_timeout_c;
    logic timeout_hit_c, len_ok_c, last_idx_c;

    uart_byte_strobe u_strobe (
        .clk      (clk),
        .rst      (rst),
        .rx_flag  (bus.rx_flag),
        .rx_byte  (bus.rx_byte),
        .byte_stb (byte_stb),
        .rx_data  (rx_data)
    );

    assign timeout_hit_c = (state != S_SYNC) && (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));
    assign len_ok_c      = (rx_data != 8'h00) && (rx_data <= 8'(MAX_LEN));
    assign last_idx_c    = (idx_q == len_q - LEN_W'(1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_SYNC;
        else     state <= state_next;
    end

    // Next state and per-cycle events; a byte strobe takes priority over timeout
    always_comb begin
        state_next    = state;
        commit_c      = 1'b0;
        err_chk_c     = 1'b0;
        err_len_c     = 1'b0;
        err_timeout_c = 1'b0;
        if (byte_stb) begin
            case (state)
                S_SYNC:    if (rx_data == SYNC_BYTE) state_next = S_ID;
                S_ID:      state_next = S_LEN;
                S_LEN: begin
                    if (len_ok_c) begin
                        state_next = S_PAYLOAD;
                    end else begin
                        err_len_c  = 1'b1;
                        state_next = S_SYNC;
                    end
                end
                S_PAYLOAD: if (last_idx_c) state_next = S_CHK;
                S_CHK: begin
                    if (rx_data != chk_q)                              err_chk_c = 1'b1;
                    else if ((id_q == BOT_ID) || (id_q == BCAST_ID))   commit_c  = 1'b1;
                    state_next = S_SYNC;
                end
                default:   state_next = S_SYNC;
            endcase
        end else if (timeout_hit_c) begin
            err_timeout_c = 1'b1;
            state_next    = S_SYNC;
        end
    end

    // Frame assembly: id, length, running checksum and shadow payload
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_q  <= 8'h00;
            chk_q <= 8'h00;
            len_q <= '0;
            idx_q <= '0;
            for (int k = 0; k < int'(MAX_LEN); k++) shadow[k] <= 8'h00;
        end else if (byte_stb) begin
            case (state)
                S_SYNC: chk_q <= 8'h00;
                S_ID: begin
                    id_q  <= rx_data;
                    chk_q <= chk_q ^ rx_data;
                end
                S_LEN: begin
                    if (len_ok_c) begin
                        len_q <= LEN_W'(rx_data);
                        idx_q <= '0;
                        chk_q <= chk_q ^ rx_data;
                        for (int k = 0; k < int'(MAX_LEN); k++) shadow[k] <= 8'h00;
                    end
                end
                S_PAYLOAD: begin
                    shadow[idx_q[IDX_W-1:0]] <= rx_data;
                    chk_q <= chk_q ^ rx_data;
                    if (!last_idx_c) idx_q <= idx_q + LEN_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Inter-byte timer, idle while hunting for sync
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q <= '0;
        end else if (byte_stb || (state == S_SYNC) || timeout_hit_c) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_q + TMR_W'(1);
        end
    end

    // Registered outputs; held frame fields change only on commit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.frame_valid   <= 1'b0;
            bus.err_chk       <= 1'b0;
            bus.err_len       <= 1'b0;
            bus.err_timeout   <= 1'b0;
            bus.busy          <= 1'b0;
            bus.frame_id      <= 8'h00;
            bus.frame_len     <= '0;
            bus.frame_payload <= '0;
        end else begin
            bus.frame_valid <= commit_c;
            bus.err_chk     <= err_chk_c;
            bus.err_len     <= err_len_c;
            bus.err_timeout <= err_timeout_c;
            bus.busy        <= (state_next != S_SYNC);
            if (commit_c) begin
                bus.frame_id  <= id_q;
                bus.frame_len <= len_q;
                for (int k = 0; k < int'(MAX_LEN); k++) begin
                    bus.frame_payload[8*k +: 8] <= shadow[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_frame_parser.sv
// Directed self-checking bench for uart_cmd_frame_parser.
module tb_uart_cmd_frame_parser;

    localparam int unsigned MAX_LEN = 8;
    localparam int unsigned TMO     = 64;

    logic clk;
    logic rst;

    uart_cmd_frame_parser_if #(.MAX_LEN(MAX_LEN)) bus ();

    uart_cmd_frame_parser #(
        .BOT_ID         (8'h01),
        .MAX_LEN        (MAX_LEN),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_valid  = 0;
    int n_echk   = 0;
    int n_elen   = 0;
    int n_eto    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled on the falling edge
    always @(negedge clk) begin
        if (bus.frame_valid) n_valid++;
        if (bus.err_chk)     n_echk++;
        if (bus.err_len)     n_elen++;
        if (bus.err_timeout) n_eto++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Called at a falling edge; each byte holds the flag hi cycles then drops it lo cycles
    task automatic send_seq(input logic [7:0] bytes[$], input int hi, input int lo);
        foreach (bytes[i]) begin
            bus.rx_byte = bytes[i];
            bus.rx_flag = 1'b1;
            repeat (hi) @(negedge clk);
            bus.rx_flag = 1'b0;
            repeat (lo) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.rx_flag = 1'b0;
        bus.rx_byte = 8'h00;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.frame_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid_busy: got %b%b expected 00", bus.frame_valid, bus.busy);
        end
        n_checks++;
        if ({bus.err_chk, bus.err_len, bus.err_timeout} !== 3'b000) begin
            n_fail++; $display("FAIL reset_errs: got %b expected 000", {bus.err_chk, bus.err_len, bus.err_timeout});
        end
        n_checks++;
        if (bus.frame_id !== 8'h00 || bus.frame_len !== 4'd0 || bus.frame_payload !== 64'h0) begin
            n_fail++; $display("FAIL reset_held: got id=%h len=%0d pl=%h expected zeros", bus.frame_id, bus.frame_len, bus.frame_payload);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_good_frame();
        logic [7:0] q[$];
        int v0, e0;
        v0 = n_valid; e0 = n_echk + n_elen + n_eto;
        q = '{8'hA5, 8'h01, 8'h02, 8'h10, 8'h20};
        send_seq(q, 1, 1);
        bus.rx_byte = 8'h33;
        bus.rx_flag = 1'b1;
        @(negedge clk);
        bus.rx_flag = 1'b0;
        n_checks++;
        if (bus.frame_valid !== 1'b0) begin
            n_fail++; $display("FAIL good_latency_early: got %b expected 0", bus.frame_valid);
        end
        @(negedge clk);
        n_checks++;
        if (bus.frame_valid !== 1'b1) begin
            n_fail++; $display("FAIL good_latency_pulse: got %b expected 1", bus.frame_valid);
        end
        @(negedge clk);
        n_checks++;
        if (bus.frame_valid !== 1'b0) begin
            n_fail++; $display("FAIL good_pulse_width: got %b expected 0", bus.frame_valid);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (n_valid - v0 !== 1 || n_echk + n_elen + n_eto - e0 !== 0) begin
            n_fail++; $display("FAIL good_counts: got valid=%0d errs=%0d expected 1/0", n_valid - v0, n_echk + n_elen + n_eto - e0);
        end
        n_checks++;
        if (bus.frame_id !== 8'h01 || bus.frame_len !== 4'd2 || bus.frame_payload !== 64'h2010) begin
            n_fail++; $display("FAIL good_fields: got id=%h len=%0d pl=%h expected 01/2/2010", bus.frame_id, bus.frame_len, bus.frame_payload);
        end
    endtask

    task automatic test_broadcast();
        logic [7:0] q[$];
        int v0;
        v0 = n_valid;
        q = '{8'hA5, 8'hFF, 8'h01, 8'h7E, 8'h80};
        send_seq(q, 1, 1);
        repeat (4) @(negedge clk);
        n_checks++;
        if (n_valid - v0 !== 1) begin
            n_fail++; $display("FAIL bcast_valid: got %0d pulses expected 1", n_valid - v0);
        end
        n_checks++;
        if (bus.frame_id !== 8'hFF || bus.frame_len !== 4'd1 || bus.frame_payload !== 64'h7E) begin
            n_fail++; $display("FAIL bcast_fields: got id=%h len=%0d pl=%h expected FF/1/7E", bus.frame_id, bus.frame_len, bus.frame_payload);
        end
    endtask

    task automatic test_bad_chk();
        logic [7:0] q[$];
        int v0, c0;
        v0 = n_valid; c0 = n_echk;
        q = '{8'hA5, 8'h01, 8'h02, 8'h10, 8'h20, 8'h00};
        send_seq(q, 1, 1);
        repeat (4) @(negedge clk);
        n_checks++;
        if (n_echk - c0 !== 1 || n_valid - v0 !== 0) begin
            n_fail++; $display("FAIL badchk_pulses: got chk=%0d valid=%0d expected 1/0", n_echk - c0, n_valid - v0);
        end
        n_checks++;
        if (bus.frame_id !== 8'hFF || bus.frame_len !== 4'd1 || bus.frame_payload !== 64'h7E) begin
            n_fail++; $display("FAIL badchk_held: got id=%h len=%0d pl=%h expected FF/1/7E", bus.frame_id, bus.frame_len, bus.frame_payload);
        end
    endtask

    task automatic test_bad_len();
        logic [7:0] q[$];
        int l0, v0;
        l0 = n_elen; v0 = n_valid;
        q = '{8'hA5, 8'h01, 8'h09};
        send_seq(q, 1, 1);
        repeat (3) @(negedge clk);
        n_checks++;
        if (n_elen - l0 !== 1 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL len9: got err_len=%0d busy=%b expected 1/0", n_elen - l0, bus.busy);
        end
        l0 = n_elen;
        q = '{8'hA5, 8'h01, 8'h00};
        send_seq(q, 1, 1);
        repeat (3) @(negedge clk);
        n_checks++;
        if (n_elen - l0 !== 1 || bus.busy !== 1'b0 || n_valid - v0 !== 0) begin
            n_fail++; $display("FAIL len0: got err_len=%0d busy=%b valid=%0d expected 1/0/0", n_elen - l0, bus.busy, n_valid - v0);
        end
    endtask

    task automatic test_timeout();
        logic [7:0] q[$];
        int cnt, t0, v0;
        bit busy_mid;
        t0 = n_eto;
        q = '{8'hA5, 8'h01, 8'h02};
        send_seq(q, 1, 1);
        bus.rx_byte = 8'h10;
        bus.rx_flag = 1'b1;
        cnt = 0;
        busy_mid = 1'b0;
        while (cnt < 300) begin
            @(negedge clk);
            cnt++;
            if (cnt == 1) bus.rx_flag = 1'b0;
            if (cnt == 30) busy_mid = bus.busy;
            if (bus.err_timeout) break;
        end
        n_checks++;
        if (cnt !== int'(TMO) + 2) begin
            n_fail++; $display("FAIL timeout_latency: got %0d cycles expected %0d", cnt, TMO + 2);
        end
        n_checks++;
        if (busy_mid !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL timeout_busy: got mid=%b end=%b expected 1/0", busy_mid, bus.busy);
        end
        @(negedge clk);
        n_checks++;
        if (bus.err_timeout !== 1'b0 || n_eto - t0 !== 1) begin
            n_fail++; $display("FAIL timeout_pulse: got now=%b count=%0d expected 0/1", bus.err_timeout, n_eto - t0);
        end
        v0 = n_valid;
        q = '{8'hA5, 8'h01, 8'h01, 8'h42, 8'h42};
        send_seq(q, 1, 1);
        repeat (4) @(negedge clk);
        n_checks++;
        if (n_valid - v0 !== 1 || bus.frame_payload !== 64'h42 || bus.frame_len !== 4'd1) begin
            n_fail++; $display("FAIL timeout_recover: got valid=%0d pl=%h len=%0d expected 1/42/1", n_valid - v0, bus.frame_payload, bus.frame_len);
        end
    endtask

    task automatic test_foreign_and_rst();
        logic [7:0] q[$];
        int s0;
        s0 = n_valid + n_echk + n_elen + n_eto;
        q = '{8'h00, 8'h3C, 8'hA5, 8'h02, 8'h01, 8'h55, 8'h56};
        send_seq(q, 1, 1);
        repeat (4) @(negedge clk);
        n_checks++;
        if (n_valid + n_echk + n_elen + n_eto - s0 !== 0 || bus.frame_payload !== 64'h42 || bus.frame_id !== 8'h01) begin
            n_fail++; $display("FAIL foreign: got pulses=%0d pl=%h id=%h expected 0/42/01", n_valid + n_echk + n_elen + n_eto - s0, bus.frame_payload, bus.frame_id);
        end
        q = '{8'hA5, 8'h01, 8'h03, 8'h11, 8'h22};
        send_seq(q, 1, 1);
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_fail++; $display("FAIL midframe_busy: got %b expected 1", bus.busy);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.frame_id !== 8'h00 || bus.frame_len !== 4'd0 || bus.frame_payload !== 64'h0) begin
            n_fail++; $display("FAIL rst_midframe: got busy=%b id=%h len=%0d pl=%h expected zeros", bus.busy, bus.frame_id, bus.frame_len, bus.frame_payload);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        q = '{8'hA5, 8'h01, 8'h01, 8'h99, 8'h99};
        send_seq(q, 1, 1);
        repeat (4) @(negedge clk);
        n_checks++;
        if (bus.frame_payload !== 64'h99 || bus.frame_len !== 4'd1) begin
            n_fail++; $display("FAIL post_rst_frame: got pl=%h len=%0d expected 99/1", bus.frame_payload, bus.frame_len);
        end
    endtask

    task automatic test_long_flag();
        logic [7:0] q[$];
        int v0, e0;
        v0 = n_valid; e0 = n_echk + n_elen + n_eto;
        q = '{8'hA5, 8'h01, 8'h03, 8'hA5, 8'h00, 8'hC3, 8'h64};
        send_seq(q, 40, 2);
        repeat (4) @(negedge clk);
        n_checks++;
        if (n_valid - v0 !== 1 || n_echk + n_elen + n_eto - e0 !== 0) begin
            n_fail++; $display("FAIL longflag_counts: got valid=%0d errs=%0d expected 1/0", n_valid - v0, n_echk + n_elen + n_eto - e0);
        end
        n_checks++;
        if (bus.frame_len !== 4'd3 || bus.frame_payload !== 64'hC300A5) begin
            n_fail++; $display("FAIL longflag_fields: got len=%0d pl=%h expected 3/C300A5", bus.frame_len, bus.frame_payload);
        end
    endtask

    task automatic test_max_len();
        logic [7:0] q[$];
        int v0;
        v0 = n_valid;
        q = '{8'hA5, 8'h01, 8'h08, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h01};
        send_seq(q, 1, 1);
        repeat (4) @(negedge clk);
        n_checks++;
        if (n_valid - v0 !== 1 || bus.frame_len !== 4'd8 || bus.frame_payload !== 64'h0807060504030201) begin
            n_fail++; $display("FAIL maxlen: got valid=%0d len=%0d pl=%h expected 1/8/0807060504030201", n_valid - v0, bus.frame_len, bus.frame_payload);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] q[$];
        int v0, e0;
        v0 = n_valid; e0 = n_echk + n_elen + n_eto;
        q = '{8'hA5, 8'h01, 8'h02, 8'h10, 8'h20, 8'h33,
              8'hA5, 8'hFF, 8'h01, 8'h7E, 8'h80};
        send_seq(q, 1, 1);
        repeat (4) @(negedge clk);
        n_checks++;
        if (n_valid - v0 !== 2 || n_echk + n_elen + n_eto - e0 !== 0) begin
            n_fail++; $display("FAIL b2b_counts: got valid=%0d errs=%0d expected 2/0", n_valid - v0, n_echk + n_elen + n_eto - e0);
        end
        n_checks++;
        if (bus.frame_id !== 8'hFF || bus.frame_payload !== 64'h7E || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL b2b_fields: got id=%h pl=%h busy=%b expected FF/7E/0", bus.frame_id, bus.frame_payload, bus.busy);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_broadcast();
        test_bad_chk();
        test_bad_len();
        test_timeout();
        test_foreign_and_rst();
        test_long_flag();
        test_max_len();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
